// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline definitions: PC-source encodings, NOP, reset PC, jump
// opcodes and the IF/ID register payload.
package pipeline_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic [1:0] PCSRC_JREG = 2'b10;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // Redirect targets are taken as-is apart from the byte offset
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage (master) and the rest of the pipeline
// plus instruction memory (slave).
interface fetch_stage_if;
    import pipeline_pkg::*;

    logic [XLEN-1:0]  imem_addr;
    logic [XLEN-1:0]  imem_rdata;
    logic [1:0]       PCSrc;
    logic [XLEN-1:0]  id_rs_data;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rt;
    logic [XLEN-1:0]  if_id_instr;
    logic [XLEN-1:0]  if_id_pc_plus4;
    logic             if_id_valid;
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic [2:0]       RegimmFunct;
    logic             id_ex_bubble;
    logic [XLEN-1:0]  perf_stall_cnt;
    logic [XLEN-1:0]  perf_flush_cnt;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  PCSrc,
        input  id_rs_data,
        input  ex_branch_taken,
        input  ex_branch_target,
        input  id_ex_mem_read,
        input  id_ex_rt,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        output OpCode,
        output Funct,
        output RegimmFunct,
        output id_ex_bubble,
        output perf_stall_cnt,
        output perf_flush_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output PCSrc,
        output id_rs_data,
        output ex_branch_taken,
        output ex_branch_target,
        output id_ex_mem_read,
        output id_ex_rt,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  OpCode,
        input  Funct,
        input  RegimmFunct,
        input  id_ex_bubble,
        input  perf_stall_cnt,
        input  perf_flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register that the
// valid instruction in IF/ID reads as rs or rt. $zero never creates a hazard.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             if_id_valid,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    output logic             stall_c
);

    // Pure combinational hazard compare
    always_comb begin
        stall_c = id_ex_mem_read && (id_ex_rt != '0) && if_id_valid &&
                  ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register: PC, next-PC selection,
// squash/stall sequencing and Control field split.
// Optional FETCH_PERF_CNT_EN: saturating stall/flush performance counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            stall_c;
    logic            squash_c;
    logic [XLEN-1:0] seq_pc_c;
    logic [XLEN-1:0] jump_pc_c;

    load_use_detect u_load_use_detect (
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .if_id_valid    (if_id_q.valid),
        .if_id_rs       (if_id_q.instr[25:21]),
        .if_id_rt       (if_id_q.instr[20:16]),
        .stall_c        (stall_c)
    );

    // Next PC and IF/ID contents in redirect/stall priority order
    always_comb begin
        seq_pc_c  = pc_q + 32'd4;
        jump_pc_c = {if_id_q.pc_plus4[31:28], if_id_q.instr[25:0], 2'b00};
        squash_c  = 1'b0;
        pc_d      = seq_pc_c;
        if_id_d   = '{instr: bus.imem_rdata, pc_plus4: seq_pc_c, valid: 1'b1};

        if (bus.ex_branch_taken) begin
            pc_d     = word_align(bus.ex_branch_target);
            if_id_d  = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
            squash_c = 1'b1;
        end else if (stall_c) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end else if (if_id_q.valid && (bus.PCSrc == PCSRC_JUMP)) begin
            pc_d     = jump_pc_c;
            if_id_d  = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
            squash_c = 1'b1;
        end else if (if_id_q.valid && (bus.PCSrc == PCSRC_JREG)) begin
            pc_d     = word_align(bus.id_rs_data);
            if_id_d  = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
            squash_c = 1'b1;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            if_id_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] perf_stall_q, perf_stall_d;
    logic [XLEN-1:0] perf_flush_q, perf_flush_d;

    // Saturating event counters; a stall overridden by a branch is not counted
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_c && !bus.ex_branch_taken && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (squash_c && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_flush_cnt = perf_flush_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.OpCode         = if_id_q.instr[31:26];
    assign bus.Funct          = if_id_q.instr[5:0];
    assign bus.RegimmFunct    = {if_id_q.instr[17], if_id_q.instr[20], if_id_q.instr[16]};
    assign bus.id_ex_bubble   = stall_c;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, j, jr, load-use,
// branch over stall, PCSrc corner cases, PC wrap and reset during a stall.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counter expectation: real count when counters are built in, else 0
    function automatic logic [31:0] cnt(input int n);
`ifdef FETCH_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.imem_rdata       = '0;
        bus.PCSrc            = 2'b00;
        bus.id_rs_data       = '0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = '0;
        bus.id_ex_mem_read   = 1'b0;
        bus.id_ex_rt         = '0;
        #1 reset = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_pc",      bus.imem_addr, 32'h0040_0000);
        check("rst_instr",   bus.if_id_instr, 32'h0);
        check("rst_pcp4",    bus.if_id_pc_plus4, 32'h0);
        check("rst_valid",   32'(bus.if_id_valid), 32'h0);
        check("rst_bubble",  32'(bus.id_ex_bubble), 32'h0);
        check("rst_stall",   bus.perf_stall_cnt, 32'h0);
        check("rst_flush",   bus.perf_flush_cnt, 32'h0);

        // Sequential fetch
        reset = 1'b0;
        bus.imem_rdata = 32'h2008_0001;
        tick();
        check("seq1_pc",     bus.imem_addr, 32'h0040_0004);
        check("seq1_instr",  bus.if_id_instr, 32'h2008_0001);
        check("seq1_pcp4",   bus.if_id_pc_plus4, 32'h0040_0004);
        check("seq1_valid",  32'(bus.if_id_valid), 32'h1);
        check("seq1_op",     32'(bus.OpCode), 32'h08);
        check("seq1_funct",  32'(bus.Funct), 32'h01);
        check("seq1_regimm", 32'(bus.RegimmFunct), 32'h0);
        bus.imem_rdata = 32'h2009_0002;
        tick();
        check("seq2_pc",     bus.imem_addr, 32'h0040_0008);
        check("seq2_instr",  bus.if_id_instr, 32'h2009_0002);
        check("seq2_pcp4",   bus.if_id_pc_plus4, 32'h0040_0008);

        // j 0x0100000 -> 0x00400000
        bus.imem_rdata = 32'h0810_0000;
        tick();
        check("j_op",        32'(bus.OpCode), 32'h02);
        check("j_pcp4",      bus.if_id_pc_plus4, 32'h0040_000C);
        bus.PCSrc = 2'b01;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("j_pc",        bus.imem_addr, 32'h0040_0000);
        check("j_instr",     bus.if_id_instr, 32'h0);
        check("j_valid",     32'(bus.if_id_valid), 32'h0);
        check("j_flush",     bus.perf_flush_cnt, cnt(1));

        // PCSrc=01 with an invalid IF/ID is ignored; fetch add $10,$8,$9
        bus.imem_rdata = 32'h0109_5020;
        tick();
        check("inv_pc",      bus.imem_addr, 32'h0040_0004);
        check("inv_instr",   bus.if_id_instr, 32'h0109_5020);
        check("inv_valid",   32'(bus.if_id_valid), 32'h1);
        check("inv_flush",   bus.perf_flush_cnt, cnt(1));
        bus.PCSrc = 2'b00;

        // Load-use on rs=8: one-cycle hold
        bus.id_ex_mem_read = 1'b1;
        bus.id_ex_rt = 5'd8;
        #1;
        check("lu_bubble",   32'(bus.id_ex_bubble), 32'h1);
        bus.imem_rdata = 32'h1111_1111;
        tick();
        check("lu_pc",       bus.imem_addr, 32'h0040_0004);
        check("lu_instr",    bus.if_id_instr, 32'h0109_5020);
        check("lu_valid",    32'(bus.if_id_valid), 32'h1);
        check("lu_stallcnt", bus.perf_stall_cnt, cnt(1));
        bus.id_ex_mem_read = 1'b0;
        #1;
        check("lu_clear",    32'(bus.id_ex_bubble), 32'h0);
        bus.imem_rdata = 32'h012A_5820;
        tick();
        check("lu_adv_pc",   bus.imem_addr, 32'h0040_0008);
        check("lu_adv_ins",  bus.if_id_instr, 32'h012A_5820);

        // $zero load destination never stalls; rt-field match does
        bus.id_ex_mem_read = 1'b1;
        bus.id_ex_rt = 5'd0;
        #1;
        check("lu_zero",     32'(bus.id_ex_bubble), 32'h0);
        bus.id_ex_rt = 5'd10;
        #1;
        check("lu_rt",       32'(bus.id_ex_bubble), 32'h1);

        // Taken branch coincident with stall: redirect wins, target aligned
        bus.ex_branch_taken = 1'b1;
        bus.ex_branch_target = 32'h0040_0102;
        tick();
        check("br_pc",       bus.imem_addr, 32'h0040_0100);
        check("br_valid",    32'(bus.if_id_valid), 32'h0);
        check("br_instr",    bus.if_id_instr, 32'h0);
        check("br_stallcnt", bus.perf_stall_cnt, cnt(1));
        check("br_flush",    bus.perf_flush_cnt, cnt(2));
        bus.ex_branch_taken = 1'b0;
        bus.id_ex_mem_read = 1'b0;

        // jr $8 with rs data 0x00400023 -> 0x00400020
        bus.imem_rdata = 32'h0100_0008;
        tick();
        check("jr_fetch_pc", bus.imem_addr, 32'h0040_0104);
        check("jr_funct",    32'(bus.Funct), 32'h08);
        bus.PCSrc = 2'b10;
        bus.id_rs_data = 32'h0040_0023;
        tick();
        check("jr_pc",       bus.imem_addr, 32'h0040_0020);
        check("jr_valid",    32'(bus.if_id_valid), 32'h0);
        check("jr_flush",    bus.perf_flush_cnt, cnt(3));
        bus.PCSrc = 2'b00;

        // REGIMM field packing
        bus.imem_rdata = 32'h0411_0010;
        tick();
        check("rg_pc",       bus.imem_addr, 32'h0040_0024);
        check("rg_regimm",   32'(bus.RegimmFunct), 32'h3);
        check("rg_op",       32'(bus.OpCode), 32'h01);

        // PC+4 wraps modulo 2^32
        bus.ex_branch_taken = 1'b1;
        bus.ex_branch_target = 32'hFFFF_FFFF;
        tick();
        check("wr_pc",       bus.imem_addr, 32'hFFFF_FFFC);
        bus.ex_branch_taken = 1'b0;
        bus.imem_rdata = 32'h0000_0000;
        tick();
        check("wr_pc2",      bus.imem_addr, 32'h0000_0000);
        check("wr_pcp4",     bus.if_id_pc_plus4, 32'h0000_0000);
        check("wr_flush",    bus.perf_flush_cnt, cnt(4));

        // PCSrc=11 behaves as sequential
        bus.PCSrc = 2'b11;
        bus.imem_rdata = 32'h0109_5020;
        tick();
        check("p11_pc",      bus.imem_addr, 32'h0000_0004);
        check("p11_valid",   32'(bus.if_id_valid), 32'h1);
        check("p11_flush",   bus.perf_flush_cnt, cnt(4));
        bus.PCSrc = 2'b00;

        // Reset asserted while a stall is active
        bus.id_ex_mem_read = 1'b1;
        bus.id_ex_rt = 5'd9;
        #1;
        check("rs_bubble",   32'(bus.id_ex_bubble), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rs_pc",       bus.imem_addr, 32'h0040_0000);
        check("rs_valid",    32'(bus.if_id_valid), 32'h0);
        check("rs_bubble0",  32'(bus.id_ex_bubble), 32'h0);
        check("rs_stall",    bus.perf_stall_cnt, 32'h0);
        check("rs_flush",    bus.perf_flush_cnt, 32'h0);
        tick();
        check("rs_hold_pc",  bus.imem_addr, 32'h0040_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
